// File: rtl/snake_body_tracker.sv
// snake_body_tracker
// Owns the snake body on a 16x16 playfield: a circular buffer of {row,col}
// segments, the registered body bitmap, apple-consumption detection and
// self/wall collision detection.
//
// Optional feature macro: SNAKE_WRAP_EN
//   defined     -> moves off an edge wrap around (4-bit overflow), no wall hits
//   not defined -> an edge-crossing move is a collision (enters DEAD)
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   step              single-cycle move tick
//   dir               00 right, 01 left, 10 up, 11 down
//   apple_valid       apple coordinate is meaningful
//   apple_x, apple_y  apple row / column
//   grn_pixels        body bitmap [row][col]
//   head_x, head_y    head row / column
//   length            current segment count
//   apple_eaten       one-cycle pulse, head landed on the apple
//   game_over         sticky collision flag
module snake_body_tracker #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      step,
    input  logic [1:0]                dir,
    input  logic                      apple_valid,
    input  logic [3:0]                apple_x,
    input  logic [3:0]                apple_y,
    output logic [15:0][15:0]         grn_pixels,
    output logic [3:0]                head_x,
    output logic [3:0]                head_y,
    output logic [$clog2(MAX_LEN):0]  length,
    output logic                      apple_eaten,
    output logic                      game_over
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int LW = PW + 1;

    typedef enum logic {RUN, DEAD} state_t;

    state_t        state, state_nxt;
    logic [7:0]    body [MAX_LEN];
    logic [PW-1:0] head_ptr, tail_ptr, head_nxt;

    logic [3:0] nr, nc;
    logic       edge_cross, wall_hit, self_hit, collide;
    logic       grow, on_tail, full, advance;
    logic [7:0] tail_cell;

    // Next head position and edge detection
    always_comb begin
        nr         = head_x;
        nc         = head_y;
        edge_cross = 1'b0;
        case (dir)
            2'b00: begin nc = head_y + 4'd1; edge_cross = (head_y == 4'hF); end
            2'b01: begin nc = head_y - 4'd1; edge_cross = (head_y == 4'h0); end
            2'b10: begin nr = head_x - 4'd1; edge_cross = (head_x == 4'h0); end
            default: begin nr = head_x + 4'd1; edge_cross = (head_x == 4'hF); end
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign wall_hit = 1'b0;
`else
    assign wall_hit = edge_cross;
`endif

    assign head_nxt  = head_ptr + 1'b1;
    assign tail_cell = body[tail_ptr];
    assign grow      = apple_valid && (nr == apple_x) && (nc == apple_y);
    assign on_tail   = ({nr, nc} == tail_cell);
    // The tail cell only counts as free when it actually vacates (no growth).
    assign self_hit  = grn_pixels[nr][nc] && !(on_tail && !grow);
    assign collide   = wall_hit || self_hit;
    assign full      = (length == LW'(MAX_LEN));
    assign advance   = (state == RUN) && step && !collide;
    assign game_over = (state == DEAD);

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == RUN && step && collide) state_nxt = DEAD;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grn_pixels  <= '0;
            for (int i = 0; i < INIT_LEN; i++) begin
                grn_pixels[4'd8][4'(8 - INIT_LEN + 1 + i)] <= 1'b1;
                body[i] <= {4'd8, 4'(8 - INIT_LEN + 1 + i)};
            end
            head_ptr    <= PW'(INIT_LEN - 1);
            tail_ptr    <= '0;
            head_x      <= 4'd8;
            head_y      <= 4'd8;
            length      <= LW'(INIT_LEN);
            apple_eaten <= 1'b0;
        end else begin
            apple_eaten <= 1'b0;
            if (advance) begin
                // When saturated, head_nxt == tail_ptr: the old tail entry is
                // read this cycle before being overwritten.
                body[head_nxt] <= {nr, nc};
                head_ptr       <= head_nxt;
                head_x         <= nr;
                head_y         <= nc;
                if (!grow || full) begin
                    if (!on_tail) grn_pixels[tail_cell[7:4]][tail_cell[3:0]] <= 1'b0;
                    tail_ptr <= tail_ptr + 1'b1;
                end else begin
                    length <= length + 1'b1;
                end
                grn_pixels[nr][nc] <= 1'b1;
                apple_eaten        <= grow;
            end
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker (built with MAX_LEN=4 so the
// saturation path is reachable). Stimulus pushes hand-computed expectations;
// a monitor pops and compares one cycle after every step/reset edge.
module tb_snake_body_tracker;

    localparam int ML = 4;
    localparam int LW = $clog2(ML) + 1;
    localparam logic [1:0] R = 2'b00, L = 2'b01, U = 2'b10, D = 2'b11;

    logic clk = 1'b0, reset = 1'b0, step = 1'b0;
    logic [1:0] dir = 2'b00;
    logic apple_valid = 1'b0;
    logic [3:0] apple_x = '0, apple_y = '0;
    logic [15:0][15:0] grn_pixels;
    logic [3:0] head_x, head_y;
    logic [LW-1:0] length;
    logic apple_eaten, game_over;

    snake_body_tracker #(.MAX_LEN(ML), .INIT_LEN(3)) dut (
        .clk(clk), .reset(reset), .step(step), .dir(dir),
        .apple_valid(apple_valid), .apple_x(apple_x), .apple_y(apple_y),
        .grn_pixels(grn_pixels), .head_x(head_x), .head_y(head_y),
        .length(length), .apple_eaten(apple_eaten), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]        hx, hy;
        logic [LW-1:0]     len;
        logic              eaten, go;
        logic [15:0][15:0] bm;
    } exp_t;

    exp_t sbq[$];
    int tests = 0, fails = 0;
    logic started = 1'b0, step_d = 1'b0, rst_d = 1'b0;

    logic [3:0]        e_hx, e_hy;
    logic [LW-1:0]     e_len;
    logic              e_go;
    logic [15:0][15:0] e_bm;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        step_d <= step;
        rst_d  <= reset;
    end

    exp_t m;
    always @(negedge clk) begin
        if (started) begin
            if (step_d || rst_d) begin
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL scoreboard_empty: got no expectation, required one (t=%0t)", $time);
                end else begin
                    m = sbq.pop_front();
                    check("head_x", head_x, m.hx);
                    check("head_y", head_y, m.hy);
                    check("length", length, m.len);
                    check("apple_eaten", apple_eaten, m.eaten);
                    check("game_over", game_over, m.go);
                    check("grn_pixels", grn_pixels, m.bm);
                end
            end else begin
                check("apple_eaten_idle", apple_eaten, 1'b0);
            end
        end
    end

    task automatic push(input logic ea);
        exp_t x;
        x.hx = e_hx; x.hy = e_hy; x.len = e_len; x.eaten = ea; x.go = e_go; x.bm = e_bm;
        sbq.push_back(x);
    endtask

    task automatic reset_exp();
        e_bm = '0;
        e_bm[8][6] = 1'b1; e_bm[8][7] = 1'b1; e_bm[8][8] = 1'b1;
        e_hx = 4'd8; e_hy = 4'd8; e_len = LW'(3); e_go = 1'b0;
    endtask

    task automatic do_reset(input logic with_step);
        @(negedge clk);
        reset = 1'b1; step = with_step; dir = R;
        reset_exp();
        push(1'b0);
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        reset = 1'b0; step = 1'b0;
    endtask

    task automatic do_step(input logic [1:0] d, input logic av, input logic [3:0] ax,
                           input logic [3:0] ay, input logic ea);
        @(negedge clk);
        dir = d; apple_valid = av; apple_x = ax; apple_y = ay; step = 1'b1;
        push(ea);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            step = 1'b0; apple_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset(1'b0);

        // Three back-to-back right moves; invalid apple on the first new head
        e_hy = 4'd9;  e_bm[8][9]  = 1'b1; e_bm[8][6] = 1'b0; do_step(R, 1'b0, 4'd8, 4'd9, 1'b0);
        e_hy = 4'd10; e_bm[8][10] = 1'b1; e_bm[8][7] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hy = 4'd11; e_bm[8][11] = 1'b1; e_bm[8][8] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(2);

        // Reset together with step: reset wins
        do_reset(1'b1);

        // Eat apple at (8,9), then plain move
        e_hy = 4'd9; e_bm[8][9] = 1'b1; e_len = LW'(4); do_step(R, 1'b1, 4'd8, 4'd9, 1'b1);
        idle(2);
        e_hy = 4'd10; e_bm[8][10] = 1'b1; e_bm[8][6] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(1);

        // 2x2 tail chase, length 4
        e_hx = 4'd9; e_bm[9][10] = 1'b1; e_bm[8][7] = 1'b0; do_step(D, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hy = 4'd9; e_bm[9][9]  = 1'b1; e_bm[8][8] = 1'b0; do_step(L, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hx = 4'd8;  do_step(U, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hy = 4'd10; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hx = 4'd9;  do_step(D, 1'b0, 4'd0, 4'd0, 1'b0);
        // Apple on the tail cell (9,9): growing into the tail is a collision
        e_go = 1'b1; do_step(L, 1'b1, 4'd9, 4'd9, 1'b0);
        do_step(D, 1'b0, 4'd0, 4'd0, 1'b0);   // ignored in DEAD
        idle(2);

        // Reversal from reset is a self-hit; reset restores
        do_reset(1'b0);
        e_go = 1'b1; do_step(L, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(1);
        do_reset(1'b0);

        // Saturation at MAX_LEN=4
        e_hy = 4'd9;  e_bm[8][9]  = 1'b1; e_len = LW'(4); do_step(R, 1'b1, 4'd8, 4'd9, 1'b1);
        e_hy = 4'd10; e_bm[8][10] = 1'b1; e_bm[8][6] = 1'b0; do_step(R, 1'b1, 4'd8, 4'd10, 1'b1);
        e_hy = 4'd11; e_bm[8][11] = 1'b1; e_bm[8][7] = 1'b0; do_step(R, 1'b1, 4'd8, 4'd11, 1'b1);
        idle(1);
        // Apple on next head but not valid: ignored
        e_hy = 4'd12; e_bm[8][12] = 1'b1; e_bm[8][8]  = 1'b0; do_step(R, 1'b0, 4'd8, 4'd12, 1'b0);
        e_hy = 4'd13; e_bm[8][13] = 1'b1; e_bm[8][9]  = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hy = 4'd14; e_bm[8][14] = 1'b1; e_bm[8][10] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hy = 4'd15; e_bm[8][15] = 1'b1; e_bm[8][11] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        idle(1);

        // Right edge
`ifdef SNAKE_WRAP_EN
        e_hy = 4'd0; e_bm[8][0] = 1'b1; e_bm[8][12] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        e_hy = 4'd1; e_bm[8][1] = 1'b1; e_bm[8][13] = 1'b0; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
`else
        e_go = 1'b1; do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
        do_step(R, 1'b0, 4'd0, 4'd0, 1'b0);
`endif
        idle(3);

        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
